uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo_pkg.sv | 29 ++
 rtl/uart_tx_fifo_if.sv | 20 ++
 rtl/uart_tx_fifo_sync_fifo.sv | 59 +++++
 rtl/uart_tx_fifo.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and helpers for the UART transmitter with integrated FIFO.
// Optional LED mirror of the last written byte is enabled with UART_TX_LED_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_t;

    function automatic logic has_parity(input logic [1:0] parity_mode);
        return (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
    endfunction

    // Serial bits in one frame: start + data + optional parity + stop bits.
    function automatic int frame_bits(input int data_bit, input logic [1:0] parity_mode,
                                      input logic two_stop);
        return 1 + data_bit + (has_parity(parity_mode) ? 1 : 0) + (two_stop ? 2 : 1);
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Valid/ready byte write port into the UART transmit FIFO.
interface uart_tx_fifo_if #(
    parameter int DATA_BIT = 8
);
    logic [DATA_BIT-1:0] wr_data;
    logic                wr_valid;
    logic                wr_ready;

    modport master (
        output wr_data,
        output wr_valid,
        input  wr_ready
    );

    modport slave (
        input  wr_data,
        input  wr_valid,
        output wr_ready
    );
endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with registered occupancy; storage is not reset, pointers are.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO, per-frame parity/stop configuration and baud divider.
// Define UART_TX_LED_EN to add the led output mirroring the last accepted byte.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BIT = 8,
    parameter int DEPTH    = 4,
    parameter int DIV_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DIV_W-1:0]         clkdiv,
    input  logic [1:0]               parity_mode,
    input  logic                     two_stop,
    uart_tx_fifo_if.slave            wr,
    input  logic                     tx_en,
    output logic                     tx,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   count,
`ifdef UART_TX_LED_EN
    output logic [DATA_BIT-1:0]      led,
`endif
    output logic                     overflow
);
    localparam int BW = $clog2(DATA_BIT);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BIT - 1);

    tx_state_t           state;
    logic [DIV_W-1:0]    timer;
    logic [DIV_W-1:0]    div_l;
    logic [BW-1:0]       bit_cnt;
    logic                stop_cnt;
    logic                two_l;
    logic                par_en;
    logic                par_bit;
    logic [DATA_BIT-1:0] shift;

    logic                full;
    logic                empty;
    logic                push;
    logic [DATA_BIT-1:0] fifo_q;
    logic                bit_end;
    logic                last_stop;
    logic                start_frame;

    assign wr.wr_ready = !full;
    assign push        = wr.wr_valid && !full;
    assign bit_end     = (timer == div_l);
    assign last_stop   = (state == STOP) && bit_end && (stop_cnt == two_l);
    // A frame can start from IDLE or directly out of the final stop cycle.
    assign start_frame = tx_en && !empty && ((state == IDLE) || last_stop);

    uart_sync_fifo #(
        .WIDTH (DATA_BIT),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (wr.wr_data),
        .pop       (start_frame),
        .pop_data  (fifo_q),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (wr.wr_valid && full) begin
            overflow <= 1'b1;
        end
    end

`ifdef UART_TX_LED_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led <= '0;
        end else if (push) begin
            led <= wr.wr_data;
        end
    end
`endif

    // Data path: shift register and precomputed parity, loaded at frame start.
    always_ff @(posedge clk) begin
        if (start_frame) begin
            shift   <= fifo_q;
            par_bit <= (parity_mode == PAR_ODD) ? ~(^fifo_q) : ^fifo_q;
        end else if ((state == DATA) && bit_end && (bit_cnt != LAST_BIT)) begin
            shift   <= shift >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            timer    <= '0;
            div_l    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            two_l    <= 1'b0;
            par_en   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                end
                START: begin
                    if (bit_end) begin
                        timer   <= '0;
                        bit_cnt <= '0;
                        tx      <= shift[0];
                        state   <= DATA;
                    end else begin
                        timer <= timer + DIV_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        timer <= '0;
                        if (bit_cnt == LAST_BIT) begin
                            if (par_en) begin
                                tx    <= par_bit;
                                state <= PARITY;
                            end else begin
                                tx       <= 1'b1;
                                stop_cnt <= 1'b0;
                                state    <= STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                            tx      <= shift[1];
                        end
                    end else begin
                        timer <= timer + DIV_W'(1);
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        timer    <= '0;
                        tx       <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= STOP;
                    end else begin
                        timer <= timer + DIV_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        timer <= '0;
                        if (stop_cnt != two_l) begin
                            stop_cnt <= 1'b1;
                        end else begin
                            done  <= 1'b1;
                            tx    <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        timer <= timer + DIV_W'(1);
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase

            // Frame start overrides the IDLE/STOP exits above and latches the config.
            if (start_frame) begin
                state  <= START;
                tx     <= 1'b0;
                busy   <= 1'b1;
                timer  <= '0;
                div_l  <= clkdiv;
                two_l  <= two_stop;
                par_en <= has_parity(parity_mode);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus randomized frames.
module tb_uart_tx_fifo;
    localparam int DATA_BIT = 8;
    localparam int DEPTH    = 4;
    localparam int DIV_W    = 16;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b1;
    logic [DIV_W-1:0]        clkdiv = '0;
    logic [1:0]              parity_mode = 2'b00;
    logic                    two_stop = 1'b0;
    logic                    tx_en = 1'b0;
    logic                    tx;
    logic                    busy;
    logic                    done;
    logic [$clog2(DEPTH):0]  count;
    logic                    overflow;
`ifdef UART_TX_LED_EN
    logic [DATA_BIT-1:0]     led;
`endif

    uart_tx_fifo_if #(.DATA_BIT(DATA_BIT)) wr_if ();

    uart_tx_fifo #(
        .DATA_BIT (DATA_BIT),
        .DEPTH    (DEPTH),
        .DIV_W    (DIV_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clkdiv      (clkdiv),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .wr          (wr_if),
        .tx_en       (tx_en),
        .tx          (tx),
        .busy        (busy),
        .done        (done),
        .count       (count),
`ifdef UART_TX_LED_EN
        .led         (led),
`endif
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] model_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle write; the model only queues what a FIFO of DEPTH entries can hold.
    task automatic push(input logic [7:0] d);
        wr_if.wr_data  = d;
        wr_if.wr_valid = 1'b1;
        if (model_q.size() < DEPTH) model_q.push_back(d);
        @(negedge clk);
        wr_if.wr_valid = 1'b0;
    endtask

    // Waits for the start bit, then checks every cycle of the frame of the oldest queued byte.
    task automatic check_frame(input string tag, input int div, input logic [1:0] pm,
                               input logic two, input int max_wait, input int exp_count,
                               input int new_div, input int new_pm);
        logic [7:0] d;
        logic       bits[$];
        int         w;
        d = model_q.pop_front();
        bits.push_back(1'b0);
        for (int i = 0; i < DATA_BIT; i++) bits.push_back(d[i]);
        if (pm == 2'b01) bits.push_back(($countones(d) % 2) == 1);
        if (pm == 2'b10) bits.push_back(($countones(d) % 2) == 0);
        bits.push_back(1'b1);
        if (two) bits.push_back(1'b1);

        w = 0;
        while (tx !== 1'b0 && w < max_wait) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_start"}, tx, 1'b0);
        if (tx !== 1'b0) return;
        if (exp_count >= 0) chk({tag, "_count"}, count, exp_count);
        if (new_div >= 0) clkdiv = DIV_W'(new_div);
        if (new_pm >= 0) parity_mode = 2'(new_pm);

        for (int b = 0; b < bits.size(); b++) begin
            for (int c = 0; c <= div; c++) begin
                chk($sformatf("%s_bit%0d_c%0d", tag, b, c), tx, bits[b]);
                chk($sformatf("%s_busy%0d", tag, b), busy, 1'b1);
                if (b != 0 || c != 0) chk($sformatf("%s_nodone%0d", tag, b), done, 1'b0);
                @(negedge clk);
            end
        end
        chk({tag, "_done"}, done, 1'b1);
    endtask

    initial begin
        logic [7:0] d;
        int         dv;
        logic [1:0] pm;
        logic       two;

        wr_if.wr_data  = '0;
        wr_if.wr_valid = 1'b0;

        // Reset state
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_count", count, 0);
        chk("rst_wr_ready", wr_if.wr_ready, 1'b1);
        chk("rst_overflow", overflow, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // 8N1, clkdiv=3, byte 0xA5
        clkdiv = 16'd3; parity_mode = 2'b00; two_stop = 1'b0; tx_en = 1'b1;
        push(8'hA5);
        check_frame("a5_8n1", 3, 2'b00, 1'b0, 4, 0, -1, -1);
        chk("a5_idle_busy", busy, 1'b0);
        chk("a5_idle_tx", tx, 1'b1);

        // Even parity, two bytes back-to-back
        parity_mode = 2'b01;
        push(8'hA5);
        push(8'h07);
        check_frame("even1", 3, 2'b01, 1'b0, 4, -1, -1, -1);
        check_frame("even2", 3, 2'b01, 1'b0, 0, 0, -1, -1);
        chk("even_idle_busy", busy, 1'b0);

        // Odd parity, two stop bits, clkdiv=0
        clkdiv = 16'd0; parity_mode = 2'b10; two_stop = 1'b1;
        push(8'h00);
        check_frame("odd2s", 0, 2'b10, 1'b1, 4, 0, -1, -1);
        @(negedge clk);

        // Fill with transmit disabled, then drain
        tx_en = 1'b0; clkdiv = 16'd1; parity_mode = 2'b00; two_stop = 1'b0;
        for (int i = 0; i < 4; i++) push(8'($urandom));
        chk("fill_count", count, DEPTH);
        chk("fill_wr_ready", wr_if.wr_ready, 1'b0);
        chk("fill_no_ovf", overflow, 1'b0);
        push(8'($urandom));
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_count", count, DEPTH);
        tx_en = 1'b1;
        check_frame("drain0", 1, 2'b00, 1'b0, 4, 3, -1, -1);
        check_frame("drain1", 1, 2'b00, 1'b0, 0, 2, -1, -1);
        check_frame("drain2", 1, 2'b00, 1'b0, 0, 1, -1, -1);
        check_frame("drain3", 1, 2'b00, 1'b0, 0, 0, -1, -1);
        chk("drain_ovf_sticky", overflow, 1'b1);

        // Config change mid-frame only applies to the next frame
        tx_en = 1'b0; clkdiv = 16'd3; parity_mode = 2'b00;
        push(8'($urandom));
        push(8'($urandom));
        tx_en = 1'b1;
        check_frame("cfg_old", 3, 2'b00, 1'b0, 4, 1, 7, 2);
        check_frame("cfg_new", 7, 2'b10, 1'b0, 0, 0, -1, -1);

        // Randomized single frames
        for (int k = 0; k < 6; k++) begin
            dv  = $urandom_range(0, 3);
            pm  = 2'($urandom_range(0, 3));
            two = 1'($urandom_range(0, 1));
            d   = 8'($urandom);
            clkdiv = DIV_W'(dv); parity_mode = pm; two_stop = two;
            push(d);
            check_frame($sformatf("rnd%0d", k), dv, pm, two, 4, 0, -1, -1);
        end

        // Asynchronous reset during the data bits
        clkdiv = 16'd3; parity_mode = 2'b00; two_stop = 1'b0; tx_en = 1'b1;
        push(8'h3C);
        push(8'hC3);
        dv = 0;
        while (tx !== 1'b0 && dv < 4) begin
            @(negedge clk);
            dv++;
        end
        chk("arst_started", tx, 1'b0);
        repeat (6) @(negedge clk);
        chk("arst_busy_before", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tx", tx, 1'b1);
        chk("arst_busy", busy, 1'b0);
        chk("arst_count", count, 0);
        chk("arst_done", done, 1'b0);
        chk("arst_ovf", overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_q.delete();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst_tx%0d", i), tx, 1'b1);
            chk($sformatf("post_rst_busy%0d", i), busy, 1'b0);
            chk($sformatf("post_rst_done%0d", i), done, 1'b0);
        end
        chk("post_rst_wr_ready", wr_if.wr_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
